// File: rtl/mem_arb_pkg.sv
// Shared types and the rotating-priority pick used by the SRAM port arbiter.
package mem_arb_pkg;

  localparam int MAX_NCH = 8;
  localparam int MAX_AW  = 32;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} arb_state_e;

  typedef struct packed {
    logic              ce;
    logic              oe;
    logic              we;
    logic [MAX_AW-1:0] addr;
    logic [7:0]        dati;
  } arb_req_t;

  // First pending index strictly after start, wrapping at nch; returns {valid, id}.
  // Fixed priority is the same search started from nch-1.
  function automatic logic [3:0] rr_pick(input logic [MAX_NCH-1:0] pend,
                                         input int nch, input logic [2:0] start);
    logic [3:0] res;
    int         idx;
    res = '0;
    for (int k = 1; k <= MAX_NCH; k++) begin
      idx = int'(start) + k;
      if (idx >= nch) idx = idx - nch;
      if (k <= nch && !res[3] && pend[idx[2:0]]) res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester bundle plus external SRAM port of one arbiter instance.
interface mem_arb_if #(
  parameter int NCH = 6,
  parameter int AW  = 23
);
  logic [NCH-1:0]         req_ce;
  logic [NCH-1:0]         req_oe;
  logic [NCH-1:0]         req_we;
  logic [NCH-1:0][AW-1:0] req_addr;
  logic [NCH-1:0][7:0]    req_dati;
  logic [NCH-1:0]         req_ack;
  logic [7:0]             req_dato;
  logic [AW-1:0]          mem_addr;
  logic [7:0]             mem_dati;
  logic [7:0]             mem_dato;
  logic                   mem_ce;
  logic                   mem_oe;
  logic                   mem_we;

  // arbiter side: serves requesters, drives the RAM
  modport master (
    input  req_ce, req_oe, req_we, req_addr, req_dati, mem_dato,
    output req_ack, req_dato, mem_addr, mem_dati, mem_ce, mem_oe, mem_we
  );

  // environment side: requesters and RAM model
  modport slave (
    output req_ce, req_oe, req_we, req_addr, req_dati, mem_dato,
    input  req_ack, req_dato, mem_addr, mem_dati, mem_ce, mem_oe, mem_we
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner pick: fixed (lowest index) or round-robin after rr_ptr.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int NCH = 6
) (
  input  logic [NCH-1:0] pend,
  input  logic           rr_mode,
  input  logic [2:0]     rr_ptr,
  output logic           valid,
  output logic [2:0]     id
);

  logic [MAX_NCH-1:0] pend_x;
  logic [2:0]         start;
  logic [3:0]         pick;

  always_comb begin
    pend_x          = '0;
    pend_x[NCH-1:0] = pend;
    start           = rr_mode ? rr_ptr : 3'(NCH-1);
    pick            = rr_pick(pend_x, NCH, start);
    valid           = pick[3];
    id              = pick[2:0];
  end

endmodule

// File: rtl/mem_arb.sv
// NCH-channel arbiter onto one SRAM port: registered grant, fixed-length strobe
// window, OR-mapped per-channel base, latched read data and one-shot ack.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int               NCH     = 6,
  parameter int               AW      = 23,
  parameter int               ACC_CYC = 2,
  parameter logic [NCH*AW-1:0] BASE   = '0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rr_mode,
  mem_arb_if.master bus,
  output logic      busy,
  output logic [2:0] gnt_id
);

  arb_state_e             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [2:0]             gnt_q, gnt_d;
  logic [2:0]             rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [AW-1:0]          raw_q, raw_d;
  logic [7:0]             dati_q, dati_d;
  logic [7:0]             dato_q, dato_d;
  logic                   ce_q, ce_d, oe_q, oe_d, we_q, we_d;
  logic [NCH-1:0]         ack_q, ack_d;
  logic [NCH-1:0]         armed_q, armed_d;
  logic [NCH-1:0][AW-1:0] stored_q, stored_d;

  logic [NCH-1:0] pend;
  logic           pick_vld;
  logic [2:0]     pick_id;
  arb_req_t       win_req;
  logic [AW-1:0]  win_raw;
  logic           unused_addr_bits;

  assign pend = bus.req_ce & (bus.req_oe | bus.req_we) & armed_q;

  arb_pick #(.NCH(NCH)) u_pick (
    .pend    (pend),
    .rr_mode (rr_mode),
    .rr_ptr  (rr_ptr_q),
    .valid   (pick_vld),
    .id      (pick_id)
  );

  always_comb begin
    win_req = '0;
    win_raw = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pick_id == 3'(i)) begin
        win_req.ce   = bus.req_ce[i];
        win_req.oe   = bus.req_oe[i];
        win_req.we   = bus.req_we[i];
        win_req.addr = MAX_AW'(bus.req_addr[i] | BASE[i*AW +: AW]);
        win_req.dati = bus.req_dati[i];
        win_raw      = bus.req_addr[i];
      end
    end
  end

  // upper bits are zero whenever AW < MAX_AW
  assign unused_addr_bits = ^win_req.addr;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    raw_d    = raw_q;
    dati_d   = dati_q;
    dato_d   = dato_q;
    ce_d     = ce_q;
    oe_d     = oe_q;
    we_d     = we_q;
    ack_d    = '0;
    stored_d = stored_q;
    // a channel re-arms once its request goes away or moves to a new address
    for (int i = 0; i < NCH; i++)
      armed_d[i] = armed_q[i] | ~(bus.req_oe[i] | bus.req_we[i]) | ~bus.req_ce[i] |
                   (bus.req_addr[i] != stored_q[i]);

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = ACC;
          cnt_d   = 4'(ACC_CYC-1);
          gnt_d   = pick_id;
          addr_d  = win_req.addr[AW-1:0];
          raw_d   = win_raw;
          dati_d  = win_req.dati;
          ce_d    = win_req.ce;
          we_d    = win_req.we;
          oe_d    = win_req.oe & ~win_req.we;
        end
      end
      ACC: begin
        if (cnt_q == 4'd0) begin
          state_d  = IDLE;
          ce_d     = 1'b0;
          oe_d     = 1'b0;
          we_d     = 1'b0;
          rr_ptr_d = gnt_q;
          if (oe_q) dato_d = bus.mem_dato;
          for (int i = 0; i < NCH; i++) begin
            if (gnt_q == 3'(i)) begin
              ack_d[i]    = 1'b1;
              armed_d[i]  = 1'b0;
              stored_d[i] = raw_q;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= '0;
      rr_ptr_q <= 3'(NCH-1);
      addr_q   <= '0;
      raw_q    <= '0;
      dati_q   <= '0;
      dato_q   <= 8'hFF;
      ce_q     <= 1'b0;
      oe_q     <= 1'b0;
      we_q     <= 1'b0;
      ack_q    <= '0;
      armed_q  <= '1;
      stored_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      raw_q    <= raw_d;
      dati_q   <= dati_d;
      dato_q   <= dato_d;
      ce_q     <= ce_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      ack_q    <= ack_d;
      armed_q  <= armed_d;
      stored_q <= stored_d;
    end
  end

  assign bus.mem_ce   = ce_q;
  assign bus.mem_oe   = oe_q;
  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_dati = dati_q;
  assign bus.req_ack  = ack_q;
  assign bus.req_dato = dato_q;
  assign busy         = (state_q == ACC);
  assign gnt_id       = gnt_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: cycle table for fixed-priority back-to-back reads,
// hand sequences for reset, round-robin, re-arm, write and ACC_CYC=1.
module tb_mem_arb;

  localparam int NCH = 6;
  localparam int AW  = 23;
  localparam logic [NCH*AW-1:0] BASE = {23'h0, 23'h400000, 23'h0, 23'h0, 23'h0, 23'h0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rr_mode = 1'b0;
  logic       busy, busy1;
  logic [2:0] gnt_id, gnt_id1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  mem_arb_if #(.NCH(NCH), .AW(AW)) bus ();
  mem_arb_if #(.NCH(2), .AW(8))    bus1 ();

  mem_arb #(.NCH(NCH), .AW(AW), .ACC_CYC(2), .BASE(BASE)) u_dut (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode), .bus(bus), .busy(busy), .gnt_id(gnt_id)
  );

  mem_arb #(.NCH(2), .AW(8), .ACC_CYC(1), .BASE(16'h0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rr_mode(rr_mode), .bus(bus1), .busy(busy1), .gnt_id(gnt_id1)
  );

  // RAM models: read data is a fixed function of the address
  assign bus.mem_dato  = bus.mem_addr[7:0] ^ bus.mem_addr[22:15];
  assign bus1.mem_dato = ~bus1.mem_addr[7:0];

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  ce, oe, we;
    logic        mce, moe, mwe;
    logic [5:0]  ack;
    logic [2:0]  gnt;
    logic [22:0] addr;
    logic [7:0]  dato;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [5:0] ce, input logic [5:0] oe, input logic [5:0] we);
    bus.req_ce = ce;
    bus.req_oe = oe;
    bus.req_we = we;
  endtask

  task automatic flush(input int n);
    set_req(6'b0, 6'b0, 6'b0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ack(input int maxcyc, output logic [5:0] got);
    got = '0;
    for (int i = 0; i < maxcyc; i++) begin
      step();
      if (bus.req_ack != 6'b0) begin
        got = bus.req_ack;
        break;
      end
    end
  endtask

  initial begin
    logic [5:0] got;
    logic [2:0] exp_ord[6];
    int         n, acks;

    exp_ord = '{3'd0, 3'd2, 3'd3, 3'd0, 3'd2, 3'd3};

    tbl[0] = '{6'b010010, 6'b010010, 6'b0, 1'b1, 1'b1, 1'b0, 6'b000000, 3'd1, 23'h000012, 8'h07};
    tbl[1] = '{6'b010010, 6'b010010, 6'b0, 1'b1, 1'b1, 1'b0, 6'b000000, 3'd1, 23'h000012, 8'h07};
    tbl[2] = '{6'b010010, 6'b010010, 6'b0, 1'b0, 1'b0, 1'b0, 6'b000010, 3'd1, 23'h000012, 8'h12};
    tbl[3] = '{6'b010010, 6'b010010, 6'b0, 1'b1, 1'b1, 1'b0, 6'b000000, 3'd4, 23'h400012, 8'h12};
    tbl[4] = '{6'b010010, 6'b010010, 6'b0, 1'b1, 1'b1, 1'b0, 6'b000000, 3'd4, 23'h400012, 8'h12};
    tbl[5] = '{6'b010010, 6'b010010, 6'b0, 1'b0, 1'b0, 1'b0, 6'b010000, 3'd4, 23'h400012, 8'h92};
    tbl[6] = '{6'b010010, 6'b010010, 6'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 3'd4, 23'h400012, 8'h92};

    bus.req_addr  = '0;
    bus.req_dati  = '0;
    bus1.req_ce   = '0;
    bus1.req_oe   = '0;
    bus1.req_we   = '0;
    bus1.req_addr = '0;
    bus1.req_dati = '0;

    // 1: reset with every channel requesting
    for (int i = 0; i < NCH; i++) bus.req_addr[i] = 23'h12;
    bus.req_addr[0] = 23'h07;
    set_req(6'h3F, 6'h3F, 6'h00);
    step();
    step();
    check("rst_mem_ce", bus.mem_ce, 1'b0);
    check("rst_mem_oe", bus.mem_oe, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_ack", bus.req_ack, 6'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dato", bus.req_dato, 8'hFF);
    check("rst_gnt", gnt_id, 3'd0);
    rst_n = 1'b1;
    step();
    check("first_gnt", gnt_id, 3'd0);
    check("first_ce", bus.mem_ce, 1'b1);
    check("first_busy", busy, 1'b1);
    check("first_addr", bus.mem_addr, 23'h07);
    set_req(6'b0, 6'b0, 6'b0);
    wait_ack(10, got);
    check("first_ack", got, 6'b000001);
    check("first_dato", bus.req_dato, 8'h07);
    flush(4);

    // 2: fixed priority, ch1 and ch4 read together, ch4 carries a base offset
    rr_mode = 1'b0;
    bus.req_addr[1] = 23'h12;
    bus.req_addr[4] = 23'h12;
    for (int k = 0; k < 7; k++) begin
      set_req(tbl[k].ce, tbl[k].oe, tbl[k].we);
      step();
      check($sformatf("tbl%0d_ce", k), bus.mem_ce, tbl[k].mce);
      check($sformatf("tbl%0d_oe", k), bus.mem_oe, tbl[k].moe);
      check($sformatf("tbl%0d_we", k), bus.mem_we, tbl[k].mwe);
      check($sformatf("tbl%0d_ack", k), bus.req_ack, tbl[k].ack);
      check($sformatf("tbl%0d_gnt", k), gnt_id, tbl[k].gnt);
      check($sformatf("tbl%0d_dato", k), bus.req_dato, tbl[k].dato);
      if (tbl[k].mce) check($sformatf("tbl%0d_addr", k), bus.mem_addr, tbl[k].addr);
    end
    flush(4);

    // 3: round robin over ch0/2/3 with toggling addresses
    rr_mode = 1'b1;
    set_req(6'b001101, 6'b001101, 6'b0);
    n = 0;
    for (int c = 0; c < 80 && n < 6; c++) begin
      bus.req_addr[0] = c[0] ? 23'h20 : 23'h21;
      bus.req_addr[2] = c[0] ? 23'h20 : 23'h21;
      bus.req_addr[3] = c[0] ? 23'h20 : 23'h21;
      step();
      if (bus.req_ack != 6'b0) begin
        check($sformatf("rr_order%0d", n), gnt_id, exp_ord[n]);
        check($sformatf("rr_ack%0d", n), bus.req_ack, 6'b1 << exp_ord[n]);
        n++;
      end
    end
    check("rr_count", n, 6);
    rr_mode = 1'b0;
    flush(6);

    // 4: held strobe on a constant address fires once; a new address fires again
    bus.req_addr[3] = 23'h44;
    set_req(6'b001000, 6'b001000, 6'b0);
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.req_ack[3]) acks++;
    end
    check("hold_acks", acks, 1);
    check("hold_dato", bus.req_dato, 8'h44);
    bus.req_addr[3] = 23'h45;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.req_ack[3]) acks++;
    end
    check("readdr_acks", acks, 1);
    check("readdr_dato", bus.req_dato, 8'h45);
    flush(4);

    // 5: oe and we together is a write
    bus.req_addr[5] = 23'h33;
    bus.req_dati[5] = 8'hA5;
    set_req(6'b100000, 6'b100000, 6'b100000);
    step();
    check("wr_ce", bus.mem_ce, 1'b1);
    check("wr_we", bus.mem_we, 1'b1);
    check("wr_oe", bus.mem_oe, 1'b0);
    check("wr_dati", bus.mem_dati, 8'hA5);
    check("wr_addr", bus.mem_addr, 23'h33);
    check("wr_gnt", gnt_id, 3'd5);
    step();
    step();
    check("wr_ack", bus.req_ack, 6'b100000);
    check("wr_dato_kept", bus.req_dato, 8'h45);
    flush(4);

    // 6: reset during the first strobe cycle aborts and restores channel 0 priority
    rr_mode = 1'b1;
    bus.req_addr[2] = 23'h50;
    set_req(6'b000100, 6'b000100, 6'b0);
    wait_ack(10, got);
    check("rr6_pre_ack", got, 6'b000100);
    flush(3);
    bus.req_addr[0] = 23'h60;
    bus.req_addr[3] = 23'h61;
    set_req(6'b001001, 6'b001001, 6'b0);
    step();
    check("rr6_gnt", gnt_id, 3'd3);
    check("rr6_ce", bus.mem_ce, 1'b1);
    rst_n = 1'b0;
    step();
    check("abort_ce", bus.mem_ce, 1'b0);
    check("abort_oe", bus.mem_oe, 1'b0);
    check("abort_ack", bus.req_ack, 6'b0);
    check("abort_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();
    check("post_rst_gnt", gnt_id, 3'd0);
    check("post_rst_ce", bus.mem_ce, 1'b1);
    check("post_rst_addr", bus.mem_addr, 23'h60);
    step();
    step();
    check("post_rst_ack", bus.req_ack, 6'b000001);
    flush(6);

    // 7: ACC_CYC=1, two channels: one strobe cycle then ack
    bus1.req_addr[1] = 8'h3C;
    bus1.req_ce = 2'b10;
    bus1.req_oe = 2'b10;
    step();
    check("c1_ce", bus1.mem_ce, 1'b1);
    check("c1_gnt", gnt_id1, 3'd1);
    step();
    check("c1_ack", bus1.req_ack, 2'b10);
    check("c1_ce_off", bus1.mem_ce, 1'b0);
    check("c1_dato", bus1.req_dato, 8'hC3);
    step();
    check("c1_no_retrig", bus1.mem_ce, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
